// File: rtl/led_axi_lite_slave.sv
// ----------------------------------------------------------------------------
// led_axi_lite_slave
//
// AXI4-Lite responder for the LED controller. It holds four 32-bit
// read/write registers and drives the LEDs from them, with an optional
// blink mode.
//
//   0x0  REG0  LED pattern, bits [NUM_LEDS-1:0]
//   0x4  REG1  blink half-period in cycles, minus 1
//   0x8  REG2  control, bit0 = blink_en
//   0xC  REG3  scratch
//
// All 32 bits of every register are stored and read back.
//
// Ports:
//   ACLK, ARESETN          clock (rising edge) and asynchronous active-low reset
//   S_AXI_AW*              write address channel (AWPROT ignored)
//   S_AXI_W*               write data channel with byte strobes
//   S_AXI_B*               write response, always OKAY
//   S_AXI_AR*              read address channel (ARPROT ignored)
//   S_AXI_R*               read data channel, always OKAY
//   led_out                registered LED drive
// ----------------------------------------------------------------------------
module led_axi_lite_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int NUM_LEDS           = 8
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [NUM_LEDS-1:0]             led_out
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int SW = C_S_AXI_DATA_WIDTH / 8;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic          aw_held_q, aw_held_d;
    logic [1:0]    awaddr_q,  awaddr_d;
    logic          w_held_q,  w_held_d;
    logic [DW-1:0] wdata_q,   wdata_d;
    logic [SW-1:0] wstrb_q,   wstrb_d;
    logic          bvalid_q,  bvalid_d;
    logic          rvalid_q,  rvalid_d;
    logic [DW-1:0] rdata_q,   rdata_d;
    logic [DW-1:0] regs_q [4];
    logic [DW-1:0] regs_d [4];
    logic [DW-1:0] cnt_q,     cnt_d;
    logic          phase_q,   phase_d;
    logic [NUM_LEDS-1:0] led_q, led_d;

    // ------------------------------------------------------------------
    // Handshakes and commit selection
    // ------------------------------------------------------------------
    logic          aw_ready, w_ready, ar_ready;
    logic          aw_hs, w_hs, ar_hs;
    logic          commit;
    logic [1:0]    cm_idx;
    logic [DW-1:0] cm_data;
    logic [SW-1:0] cm_strb;
    logic [DW-1:0] wmask;
    logic          blink_en;
    logic          cfg_commit;

    assign aw_ready = !aw_held_q && !bvalid_q;
    assign w_ready  = !w_held_q  && !bvalid_q;
    assign ar_ready = !rvalid_q;

    assign aw_hs = S_AXI_AWVALID && aw_ready;
    assign w_hs  = S_AXI_WVALID  && w_ready;
    assign ar_hs = S_AXI_ARVALID && ar_ready;

    // A half is available if it was held earlier or is handshaking now;
    // the write commits on the first edge where both halves are available.
    assign commit  = (aw_held_q || aw_hs) && (w_held_q || w_hs);
    assign cm_idx  = aw_held_q ? awaddr_q : S_AXI_AWADDR[3:2];
    assign cm_data = w_held_q  ? wdata_q  : S_AXI_WDATA;
    assign cm_strb = w_held_q  ? wstrb_q  : S_AXI_WSTRB;

    // Expand byte strobes into a bit mask.
    generate
        for (genvar gi = 0; gi < SW; gi++) begin : g_lane
            assign wmask[8*gi +: 8] = {8{cm_strb[gi]}};
        end
    endgenerate

    assign blink_en   = regs_q[2][0];
    assign cfg_commit = commit && ((cm_idx == 2'd1) || (cm_idx == 2'd2));

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        aw_held_d = aw_held_q;
        awaddr_d  = awaddr_q;
        w_held_d  = w_held_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;

        if (aw_hs) begin
            aw_held_d = 1'b1;
            awaddr_d  = S_AXI_AWADDR[3:2];
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            wdata_d  = S_AXI_WDATA;
            wstrb_d  = S_AXI_WSTRB;
        end

        // Commit takes priority over the capture above so both flags end clear.
        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
        end else if (bvalid_q && S_AXI_BREADY) begin
            bvalid_d  = 1'b0;
        end

        for (int i = 0; i < 4; i++) begin
            regs_d[i] = regs_q[i];
            if (commit && (cm_idx == 2'(i))) begin
                regs_d[i] = (regs_q[i] & ~wmask) | (cm_data & wmask);
            end
        end
    end

    // Reads sample the pre-edge register value, so a read captured on the
    // same edge as a commit to that register returns the old contents.
    always_comb begin
        rdata_d  = rdata_q;
        rvalid_d = rvalid_q;
        if (ar_hs) begin
            rdata_d  = regs_q[S_AXI_ARADDR[3:2]];
            rvalid_d = 1'b1;
        end else if (rvalid_q && S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end
    end

    // Blink timer. A config commit restarts it, so lowering REG1 below the
    // running count never needs a wrap-around.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (cfg_commit || !blink_en) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q == regs_q[1]) begin
            cnt_d   = '0;
            phase_d = !phase_q;
        end else begin
            cnt_d   = cnt_q + 1'b1;
        end

        led_d = (blink_en && phase_q) ? '0 : regs_q[0][NUM_LEDS-1:0];
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_held_q <= 1'b0;
            awaddr_q  <= '0;
            w_held_q  <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            cnt_q     <= '0;
            phase_q   <= 1'b0;
            led_q     <= '0;
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            aw_held_q <= aw_held_d;
            awaddr_q  <= awaddr_d;
            w_held_q  <= w_held_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            cnt_q     <= cnt_d;
            phase_q   <= phase_d;
            led_q     <= led_d;
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign S_AXI_AWREADY = aw_ready;
    assign S_AXI_WREADY  = w_ready;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_ARREADY = ar_ready;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = 2'b00;
    assign S_AXI_RVALID  = rvalid_q;
    assign led_out       = led_q;

    // Protection bits and the byte-offset address bits carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

endmodule

// File: tb/tb_led_axi_lite_slave.sv
// ----------------------------------------------------------------------------
// tb_led_axi_lite_slave
//
// Directed bench for led_axi_lite_slave. Inputs are driven and outputs
// sampled on the falling clock edge; the DUT acts on the rising edge.
// ----------------------------------------------------------------------------
module tb_led_axi_lite_slave;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [3:0]  awaddr = '0;
    logic [2:0]  awprot = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [3:0]  araddr = '0;
    logic [2:0]  arprot = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [7:0]  led_out;

    int checks   = 0;
    int failures = 0;

    always #5 aclk = ~aclk;

    led_axi_lite_slave #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (4),
        .NUM_LEDS           (8)
    ) dut (
        .ACLK          (aclk),
        .ARESETN       (aresetn),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .led_out       (led_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s = 0x%08h", tag, got);
        end
    endtask

    // Full write with AW and W presented together and BREADY high.
    // Returns on the falling edge after the B handshake.
    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
        bit aw_done = 0;
        bit w_done  = 0;
        bit aw_fire, w_fire;
        int n = 0;
        @(negedge aclk);
        awaddr = addr; awvalid = 1'b1;
        wdata = data; wstrb = strb; wvalid = 1'b1;
        bready = 1'b1;
        while (!(aw_done && w_done) && n < 20) begin
            aw_fire = awvalid && awready;
            w_fire  = wvalid && wready;
            @(posedge aclk);
            @(negedge aclk);
            n++;
            if (aw_fire) begin awvalid = 1'b0; aw_done = 1; end
            if (w_fire)  begin wvalid  = 1'b0; w_done  = 1; end
        end
        if (!(aw_done && w_done)) check("wr_handshake_timeout", 32'd0, 32'd1);
        n = 0;
        while (!bvalid && n < 20) begin @(negedge aclk); n++; end
        check("wr_bvalid", 32'(bvalid), 32'd1);
        check("wr_bresp",  32'(bresp),  32'd0);
        @(negedge aclk);
        check("wr_bdone",  32'(bvalid), 32'd0);
    endtask

    // Full read with RREADY high; returns the captured data.
    task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
        int n = 0;
        @(negedge aclk);
        araddr = addr; arvalid = 1'b1; rready = 1'b1;
        while (!arready && n < 20) begin @(negedge aclk); n++; end
        @(negedge aclk);
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin @(negedge aclk); n++; end
        check("rd_rvalid", 32'(rvalid), 32'd1);
        check("rd_rresp",  32'(rresp),  32'd0);
        data = rdata;
        @(negedge aclk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;

        // ---------------- reset state ----------------
        repeat (3) @(negedge aclk);
        check("rst_bvalid",  32'(bvalid),  32'd0);
        check("rst_rvalid",  32'(rvalid),  32'd0);
        check("rst_rdata",   rdata,        32'd0);
        check("rst_led",     32'(led_out), 32'd0);
        check("rst_awready", 32'(awready), 32'd1);
        aresetn = 1'b1;

        // ---------------- sequential write / read ----------------
        axi_write(4'h0, 32'h1, 4'hF);
        check("seq_led", 32'(led_out), 32'h01);
        axi_write(4'h4, 32'h2, 4'hF);
        axi_write(4'h8, 32'h3, 4'hF);
        axi_write(4'hC, 32'h4, 4'hF);
        for (int i = 0; i < 4; i++) begin
            logic [3:0] a;
            a = 4'(i * 4);
            axi_read(a, rd);
            check($sformatf("seq_rd%0d", i), rd, 32'(i + 1));
        end
        // Turn blink off again (REG2=3 enabled it).
        axi_write(4'h8, 32'h0, 4'hF);

        // ---------------- channel ordering: W first ----------------
        @(negedge aclk);
        wdata = 32'hA5; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
        @(negedge aclk);
        wvalid = 1'b0;
        check("ordw_wready_low", 32'(wready), 32'd0);
        @(negedge aclk);
        @(negedge aclk);
        awaddr = 4'h0; awvalid = 1'b1;
        check("ordw_bvalid_pre", 32'(bvalid), 32'd0);
        @(negedge aclk);
        awvalid = 1'b0;
        check("ordw_bvalid", 32'(bvalid), 32'd1);
        check("ordw_led_old", 32'(led_out), 32'h01);
        @(negedge aclk);
        check("ordw_led_new", 32'(led_out), 32'hA5);
        check("ordw_bdone", 32'(bvalid), 32'd0);

        // ---------------- channel ordering: AW first ----------------
        awaddr = 4'h0; awvalid = 1'b1;
        @(negedge aclk);
        awvalid = 1'b0;
        check("orda_awready_low", 32'(awready), 32'd0);
        @(negedge aclk);
        @(negedge aclk);
        wdata = 32'h3C; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge aclk);
        wvalid = 1'b0;
        check("orda_bvalid", 32'(bvalid), 32'd1);
        check("orda_led_old", 32'(led_out), 32'hA5);
        @(negedge aclk);
        check("orda_led_new", 32'(led_out), 32'h3C);

        // ---------------- byte strobes ----------------
        axi_write(4'hC, 32'hFFFF_FFFF, 4'hF);
        axi_write(4'hC, 32'h1234_5678, 4'b0101);
        axi_read(4'hC, rd);
        check("strb_0101", rd, 32'hFF34_FF78);
        axi_write(4'hC, 32'h0000_0000, 4'b0000);
        axi_read(4'hC, rd);
        check("strb_zero", rd, 32'hFF34_FF78);

        // ---------------- write backpressure ----------------
        @(negedge aclk);
        awaddr = 4'hC; awvalid = 1'b1;
        wdata = 32'h11; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
        @(negedge aclk);
        wvalid = 1'b0;                    // AWVALID stays up: a second write
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_bvalid%0d", i),  32'(bvalid),  32'd1);
            check($sformatf("bp_awready%0d", i), 32'(awready), 32'd0);
            check($sformatf("bp_wready%0d", i),  32'(wready),  32'd0);
            @(negedge aclk);
        end
        bready = 1'b1;
        @(negedge aclk);
        check("bp_bdone", 32'(bvalid), 32'd0);
        check("bp_aw_not_yet", 32'(awready), 32'd1);
        @(negedge aclk);
        check("bp_aw2_taken", 32'(awready), 32'd0);
        awvalid = 1'b0;
        wdata = 32'h22; wvalid = 1'b1;
        @(negedge aclk);
        wvalid = 1'b0;
        check("bp_b2_valid", 32'(bvalid), 32'd1);
        @(negedge aclk);
        check("bp_b2_done", 32'(bvalid), 32'd0);
        axi_read(4'hC, rd);
        check("bp_reg3", rd, 32'h22);

        // ---------------- read backpressure ----------------
        @(negedge aclk);
        araddr = 4'h0; arvalid = 1'b1; rready = 1'b0;
        @(negedge aclk);
        arvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rbp_rvalid%0d", i),  32'(rvalid),  32'd1);
            check($sformatf("rbp_rdata%0d", i),   rdata,        32'h3C);
            check($sformatf("rbp_arready%0d", i), 32'(arready), 32'd0);
            @(negedge aclk);
        end
        rready = 1'b1;
        @(negedge aclk);
        check("rbp_done", 32'(rvalid), 32'd0);

        // ---------------- blink ----------------
        axi_write(4'h0, 32'h0F, 4'hF);
        axi_write(4'h4, 32'h3, 4'hF);
        axi_write(4'h8, 32'h1, 4'hF);
        for (int k = 0; k < 12; k++) begin
            logic [31:0] exp;
            exp = ((k / 4) % 2 == 0) ? 32'h0F : 32'h00;
            check($sformatf("blink4_%0d", k), 32'(led_out), exp);
            @(negedge aclk);
        end
        axi_write(4'h4, 32'h0, 4'hF);
        for (int k = 0; k < 4; k++) begin
            logic [31:0] exp;
            exp = (k % 2 == 0) ? 32'h0F : 32'h00;
            check($sformatf("blink1_%0d", k), 32'(led_out), exp);
            @(negedge aclk);
        end
        axi_write(4'h8, 32'h0, 4'hF);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("steady_%0d", k), 32'(led_out), 32'h0F);
            @(negedge aclk);
        end

        // ---------------- reset mid-operation ----------------
        awaddr = 4'h0; awvalid = 1'b1; bready = 1'b1;
        @(negedge aclk);
        awvalid = 1'b0;
        check("mr_aw_held", 32'(awready), 32'd0);
        #2 aresetn = 1'b0;
        #1;
        check("mr_led",     32'(led_out), 32'd0);
        check("mr_rdata",   rdata,        32'd0);
        check("mr_bvalid",  32'(bvalid),  32'd0);
        check("mr_rvalid",  32'(rvalid),  32'd0);
        check("mr_awready", 32'(awready), 32'd1);
        @(negedge aclk);
        aresetn = 1'b1;
        wdata = 32'hDEAD; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge aclk);
        wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("mr_no_b%0d", i), 32'(bvalid), 32'd0);
            @(negedge aclk);
        end
        for (int i = 0; i < 4; i++) begin
            logic [3:0] a;
            a = 4'(i * 4);
            axi_read(a, rd);
            check($sformatf("mr_rd%0d", i), rd, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
